// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: address and instruction widths, PC step,
// and the {pc, instr} record carried through the fetch buffer.
package mips_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: memory read port, decode valid/ready handshake,
// redirect request and buffer occupancy.
interface instruction_fetch_if
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instruct;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [LVL_W-1:0]   level;

  modport master (
    output pc,
    input  instruct,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect,
    input  redirect_pc,
    output level
  );

  modport slave (
    input  pc,
    output instruct,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect,
    output redirect_pc,
    input  level
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; push is accepted
// when full only if a pop happens in the same cycle.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    empty  = (r_count == '0);
    full   = (r_count == CNT_W'(DEPTH));
    w_pop  = pop && !flush && !empty;
    w_push = push && !flush && (!full || w_pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, captures {pc, instruct} into a small buffer
// and hands it to decode over valid/ready, with flush-and-redirect.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  logic [ADDR_W-1:0]      r_pc;
  fetch_entry_t           w_head;
  fetch_entry_t           w_entry;
  logic                   w_empty;
  logic                   w_full;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_push;
  logic                   w_pop;

  // Redirect wins over both push and pop in the same cycle.
  always_comb begin
    w_pop   = !w_empty && bus.out_ready && !bus.redirect;
    w_push  = !bus.redirect && (!w_full || w_pop);
    w_entry = '{pc: r_pc, instr: bus.instruct};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (bus.redirect) begin
      r_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(PC_STEP);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (w_push),
    .push_data (w_entry),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  // Storage is not reset, so an empty buffer is presented as zeros.
  assign bus.pc        = r_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_instr = w_empty ? '0 : w_head.instr;
  assign bus.out_pc    = w_empty ? '0 : w_head.pc;
  assign bus.level     = w_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, async-reset sequence,
// and random traffic against a queue-based reference model.
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instruction_fetch_if #(.DEPTH(DEPTH)) bus ();

  instruction_fetch #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: word at address a is {24'h0, a}.
  assign bus.instruct = 32'(bus.pc);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input bit v, input logic [7:0] opc,
                          input logic [7:0] pc, input int lvl);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".out_pc"}, 32'(bus.out_pc), v ? 32'(opc) : 32'h0);
    chk({tag, ".out_instr"}, bus.out_instr, v ? 32'(opc) : 32'h0);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(pc));
    chk({tag, ".level"}, 32'(bus.level), 32'(lvl));
  endtask

  typedef struct {
    bit         rst_first;
    bit         ready;
    bit         redir;
    logic [7:0] rpc;
    bit         e_valid;
    logic [7:0] e_out_pc;
    logic [7:0] e_pc;
    int         e_level;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ref_ent_t;

  ref_ent_t   q[$];
  logic [7:0] m_pc;

  initial begin
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // rst_first ready redir rpc | valid out_pc pc level  (state after the edge)
    tbl.push_back('{1, 1, 0, 8'h00, 1, 8'h00, 8'h04, 1}); // free-run
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h04, 8'h08, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h08, 8'h0C, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 1, 8'h00, 8'h04, 1}); // backpressure
    tbl.push_back('{0, 0, 0, 8'h00, 1, 8'h00, 8'h08, 2});
    tbl.push_back('{0, 0, 0, 8'h00, 1, 8'h00, 8'h08, 2});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h04, 8'h0C, 2});
    tbl.push_back('{0, 0, 1, 8'h41, 0, 8'h00, 8'h40, 0}); // redirect while full
    tbl.push_back('{0, 0, 0, 8'h00, 1, 8'h40, 8'h44, 1});
    tbl.push_back('{0, 1, 1, 8'hF8, 0, 8'h00, 8'hF8, 0}); // wrap
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'hF8, 8'hFC, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'hFC, 8'h00, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h00, 8'h04, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h04, 8'h08, 1});
    tbl.push_back('{0, 1, 1, 8'h23, 0, 8'h00, 8'h20, 0}); // redirect + pop
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h20, 8'h24, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 1, 8'h24, 8'h28, 1});

    do_reset();
    chk_outs("reset", 0, 8'h00, 8'h00, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) begin
        do_reset();
        chk_outs($sformatf("row%0d.rst", i), 0, 8'h00, 8'h00, 0);
      end
      bus.out_ready   = tbl[i].ready;
      bus.redirect    = tbl[i].redir;
      bus.redirect_pc = tbl[i].rpc;
      tick();
      chk_outs($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_out_pc,
               tbl[i].e_pc, tbl[i].e_level);
    end
    bus.redirect = 1'b0;

    // Async reset asserted between edges, then restart from 0.
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk_outs("pre_areset", 1, 8'h08, 8'h0C, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("areset", 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_outs("areset_rel", 0, 8'h00, 8'h00, 0);
    tick();
    chk_outs("restart0", 1, 8'h00, 8'h04, 1);
    tick();
    chk_outs("restart1", 1, 8'h04, 8'h08, 1);

    // Random traffic against the queue model.
    do_reset();
    q.delete();
    m_pc = 8'h00;
    for (int c = 0; c < 400; c++) begin
      bit         rdy;
      bit         rdr;
      logic [7:0] rpc;
      bit         was_full;
      bit         popped;
      chk_outs($sformatf("rnd%0d", c), q.size() != 0,
               (q.size() != 0) ? q[0].pc : 8'h00, m_pc, q.size());
      rdy = ($urandom_range(99) < 65);
      rdr = ($urandom_range(99) < 8);
      rpc = 8'($urandom);
      bus.out_ready   = rdy;
      bus.redirect    = rdr;
      bus.redirect_pc = rpc;
      if (rdr) begin
        q.delete();
        m_pc = rpc & 8'hFC;
      end else begin
        was_full = (q.size() == DEPTH);
        popped   = rdy && (q.size() != 0);
        if (popped) void'(q.pop_front());
        if (!was_full || popped) begin
          q.push_back('{m_pc, 32'(m_pc)});
          m_pc = m_pc + 8'd4;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
